shift_seq_ctrl: RTL
===================

Name: shift_seq_ctrl

Overview:
- Multi-cycle sequencer for the 16-bit logical/rotate shifter datapath.
- Uses one shared set of per-stage shift hardware (stage sizes 8, 4, 2, 1) and applies one stage per cycle, selected by the shift-count bits, MSB first.
- Accepts a shift request through a start/busy/done handshake and returns a registered result.
- Sits beside the execute-stage ALU; used when the combinational barrel path is bypassed for timing.

Parameters:
- WIDTH, 16, data width in bits; must equal 2**CNT_W.
- CNT_W, 4, shift-count width; also the number of stage cycles.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- op  input  2  operation code: 00 ROL, 01 SLL, 10 ROR, 11 SRL; captured with start.
- in  input  WIDTH  operand; captured with start.
- cnt  input  CNT_W  shift amount, 0..15; captured with start.
- busy  output  1  high while a request is in flight (stage states).
- done  output  1  one-cycle pulse; result valid on out in the same cycle.
- out  output  WIDTH  result register; holds its value until the next done.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; busy = 0; done = 0.
  - out = 0x0000; the internal operand, count and op registers are cleared.
  - Reset takes effect immediately, including mid-operation. The in-flight request is discarded and no done is produced.
- States: IDLE, ST8, ST4, ST2, ST1, DONE.
- IDLE:
  - If start = 1, capture in, cnt and op into internal registers, then go to ST8.
  - Otherwise stay in IDLE.
- Stage states:
  - ST8 -> ST4 -> ST2 -> ST1 -> DONE, unconditionally, one cycle each.
  - Each state uses a fixed count bit: ST8 uses cnt[3], ST4 uses cnt[2], ST2 uses cnt[1], ST1 uses cnt[0].
  - If that bit is 1, the working register is replaced by itself shifted or rotated by the stage amount (8, 4, 2 or 1). If the bit is 0, the working register is unchanged.
- Stage arithmetic:
  - SLL: shift left, fill vacated bits with 0.
  - SRL: shift right, fill vacated bits with 0.
  - ROL and ROR: wrap bits around, so no bits are lost.
  - Arithmetic shift is not supported.
- busy = 1 in ST8, ST4, ST2 and ST1; busy = 0 in IDLE and DONE.
- DONE:
  - done = 1 for exactly this cycle.
  - out is loaded with the final working value on the edge entering DONE, so out is valid while done = 1.
  - Next state: if start = 1, capture the new operands and go to ST8 (back-to-back requests, no idle bubble). Otherwise go to IDLE.
- Latency: start sampled at edge N, done high in the cycle after edge N+4. This is fixed at 5 cycles for every cnt value, including cnt = 0.
- start while busy = 1 is ignored; no queueing and no error flag.
- in, cnt and op may change freely after capture; they have no effect until the next accepted start.
- cnt = 0: result equals the operand for all op codes.
- cnt = 15 with SLL or SRL: only one original bit survives.
- Rotate by any amount never loses bits; after ROL or ROR, the population count of out equals that of in.
- op = ROL with cnt = k gives the same result as op = ROR with cnt = 16-k, for k = 1..15.

Test Plan:
- Reset then idle -> out = 0x0000, busy = 0, done = 0. Deassert rst_n with start held low for 10 cycles -> no done pulse.
- Basic operations, one request each -> done exactly 5 cycles after start:
  - SRL in=0xF0F0 cnt=3 -> out = 0x1E1E.
  - SLL in=0x0001 cnt=15 -> out = 0x8000.
  - ROL in=0x8001 cnt=1 -> out = 0x0003.
  - ROR in=0x1234 cnt=4 -> out = 0x4123.
- cnt=0, all four op codes, in=0xA5C3 -> out = 0xA5C3 each time; done still arrives at the 5-cycle latency.
- Start pulses while busy: pulse start at cycles 2 and 3 of a SRL 0xFFFF cnt=8 request, with different in values -> single done, out = 0x00FF, no extra request processed.
- Back-to-back: assert start during DONE with ROR 0x0001 cnt=1 -> next done 5 cycles later, out = 0x8000. The first result remains on out until that done.
- Reset mid-operation: drop rst_n during ST4 of SLL 0x1111 cnt=12 -> out = 0x0000 and busy = 0 at once, no done. A new request after release (SRL 0x8000 cnt=15) -> out = 0x0001.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle 16-bit rotate/logical shifter sequencer.
// One stage (8, 4, 2, 1) is applied per cycle, MSB of the count first, so a
// request always takes five cycles from accepted start to the done pulse.
module shift_seq_ctrl #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] in,
   input  logic [CNT_W-1:0] cnt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ST8  = 3'd1,
      ST4  = 3'd2,
      ST2  = 3'd3,
      ST1  = 3'd4,
      DONE = 3'd5
   } state_t;

   localparam logic [1:0] OP_ROL = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_ROR = 2'b10;
   localparam logic [1:0] OP_SRL = 2'b11;

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [CNT_W-1:0] cnt_r;
   logic [1:0]       op_r;

   // One shared stage of the shifter; amt is always 1..WIDTH/2, never 0.
   function automatic logic [WIDTH-1:0] stage_shift(
      input logic [WIDTH-1:0] v,
      input logic [1:0]       opc,
      input int               amt
   );
      logic [WIDTH-1:0] r;
      case (opc)
         OP_ROL:  r = (v << amt) | (v >> (WIDTH - amt));
         OP_SLL:  r = v << amt;
         OP_ROR:  r = (v >> amt) | (v << (WIDTH - amt));
         OP_SRL:  r = v >> amt;
         default: r = v;
      endcase
      return r;
   endfunction

   // Conditionally apply one stage when the selecting count bit is set.
   function automatic logic [WIDTH-1:0] stage_apply(
      input logic [WIDTH-1:0] v,
      input logic [1:0]       opc,
      input logic             en,
      input int               amt
   );
      return en ? stage_shift(v, opc, amt) : v;
   endfunction

   // Sequencer: captures requests, walks ST8..ST1, registers the result on entry to DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         out   <= '0;
         work  <= '0;
         cnt_r <= '0;
         op_r  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  work  <= in;
                  cnt_r <= cnt;
                  op_r  <= op;
                  busy  <= 1'b1;
                  state <= ST8;
               end
            end
            ST8: begin
               work  <= stage_apply(work, op_r, cnt_r[3], 8);
               state <= ST4;
            end
            ST4: begin
               work  <= stage_apply(work, op_r, cnt_r[2], 4);
               state <= ST2;
            end
            ST2: begin
               work  <= stage_apply(work, op_r, cnt_r[1], 2);
               state <= ST1;
            end
            ST1: begin
               // Last stage feeds out directly so the result is valid with done.
               work  <= stage_apply(work, op_r, cnt_r[0], 1);
               out   <= stage_apply(work, op_r, cnt_r[0], 1);
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               if (start) begin
                  work  <= in;
                  cnt_r <= cnt;
                  op_r  <= op;
                  busy  <= 1'b1;
                  state <= ST8;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
